// File: rtl/descr_frame_ctrl_if.sv
// Link-side signal bundle for the descrambler framing controller.
// master drives enable and descrambled bits; slave is the controller.
interface descr_frame_ctrl_if;
  logic        en_i;
  logic        descr_bit_i;
  logic        descr_rstn_o;
  logic        lock_o;
  logic        frame_start_o;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic [15:0] frame_cnt_o;
  logic [15:0] miss_total_o;

  modport master (
    output en_i, descr_bit_i,
    input  descr_rstn_o, lock_o, frame_start_o, byte_o, byte_valid_o, frame_cnt_o, miss_total_o
  );

  modport slave (
    input  en_i, descr_bit_i,
    output descr_rstn_o, lock_o, frame_start_o, byte_o, byte_valid_o, frame_cnt_o, miss_total_o
  );
endinterface

// File: rtl/descr_frame_ctrl.sv
// Sequencing/framing controller for a 12-bit self-synchronising descrambler.
// Define DESCR_FRAME_STATS_EN to build the good-sync and sync-miss counters.
module descr_frame_ctrl #(
  parameter int unsigned       SYNC_W      = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD   = 16'hA5F0,
  parameter int unsigned       FRAME_BYTES = 8,
  parameter int unsigned       MISS_MAX    = 3,
  parameter int unsigned       FLUSH_LEN   = 12
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  descr_frame_ctrl_if.slave  bus
);

  localparam int unsigned PayloadBits = FRAME_BYTES * 8;
  localparam int unsigned CntMax0 = (FLUSH_LEN > PayloadBits) ? FLUSH_LEN : PayloadBits;
  localparam int unsigned CntMax  = (CntMax0 > SYNC_W) ? CntMax0 : SYNC_W;
  localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned MissW   = $clog2(MISS_MAX + 1);

  typedef enum logic [2:0] {StIdle, StFlush, StSearch, StPayload, StSync} state_e;

  state_e            r_state_q, r_state_d;
  logic [CntW-1:0]   r_cnt_q, r_cnt_d;
  logic [MissW-1:0]  r_miss_q, r_miss_d;
  logic [SYNC_W-1:0] r_shreg_q, r_shreg_d;
  logic [6:0]        r_byte_sr_q, r_byte_sr_d;
  logic [7:0]        r_byte_q, r_byte_d;
  logic              r_byte_valid_q, r_byte_valid_d;
  logic              r_frame_start_q, r_frame_start_d;
  logic              r_lock_q, r_lock_d;
  logic              r_descr_rstn_q, r_descr_rstn_d;

  logic [SYNC_W-1:0] w_shift;
  logic [7:0]        w_byte;
  logic              w_search_full;

  assign w_shift       = {r_shreg_q[SYNC_W-2:0], bus.descr_bit_i};
  assign w_byte        = {r_byte_sr_q, bus.descr_bit_i};
  assign w_search_full = (r_cnt_q == CntW'(SYNC_W - 1));

  always_comb begin
    r_state_d       = r_state_q;
    r_cnt_d         = r_cnt_q;
    r_miss_d        = r_miss_q;
    r_shreg_d       = r_shreg_q;
    r_byte_sr_d     = r_byte_sr_q;
    r_byte_d        = r_byte_q;
    r_byte_valid_d  = 1'b0;
    r_frame_start_d = 1'b0;
    r_lock_d        = r_lock_q;

    // Disable wins over everything, including a byte completing this cycle.
    if (r_state_q != StIdle && !bus.en_i) begin
      r_state_d = StIdle;
      r_lock_d  = 1'b0;
      r_miss_d  = '0;
      r_cnt_d   = '0;
    end else begin
      unique case (r_state_q)
        StIdle: begin
          if (bus.en_i) begin
            r_state_d = StFlush;
            r_cnt_d   = '0;
            r_shreg_d = '0;
          end
        end
        StFlush: begin
          if (r_cnt_q == CntW'(FLUSH_LEN - 1)) begin
            r_state_d = StSearch;
            r_cnt_d   = '0;
          end else begin
            r_cnt_d = r_cnt_q + CntW'(1);
          end
        end
        StSearch: begin
          r_shreg_d = w_shift;
          if (w_search_full && w_shift == SYNC_WORD) begin
            r_state_d       = StPayload;
            r_cnt_d         = '0;
            r_lock_d        = 1'b1;
            r_frame_start_d = 1'b1;
          end else if (!w_search_full) begin
            r_cnt_d = r_cnt_q + CntW'(1);
          end
        end
        StPayload: begin
          r_byte_sr_d = w_byte[6:0];
          if (r_cnt_q[2:0] == 3'b111) begin
            r_byte_d       = w_byte;
            r_byte_valid_d = 1'b1;
          end
          if (r_cnt_q == CntW'(PayloadBits - 1)) begin
            r_state_d = StSync;
            r_cnt_d   = '0;
          end else begin
            r_cnt_d = r_cnt_q + CntW'(1);
          end
        end
        StSync: begin
          r_shreg_d = w_shift;
          if (r_cnt_q == CntW'(SYNC_W - 1)) begin
            r_cnt_d = '0;
            if (w_shift == SYNC_WORD) begin
              r_state_d       = StPayload;
              r_miss_d        = '0;
              r_frame_start_d = 1'b1;
            end else if (r_miss_q == MissW'(MISS_MAX - 1)) begin
              // Descrambler self-resyncs, so only the framer re-hunts.
              r_state_d = StSearch;
              r_lock_d  = 1'b0;
              r_miss_d  = '0;
            end else begin
              r_state_d = StPayload;
              r_miss_d  = r_miss_q + MissW'(1);
            end
          end else begin
            r_cnt_d = r_cnt_q + CntW'(1);
          end
        end
        default: r_state_d = StIdle;
      endcase
    end

    r_descr_rstn_d = (r_state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state_q       <= StIdle;
      r_cnt_q         <= '0;
      r_miss_q        <= '0;
      r_shreg_q       <= '0;
      r_byte_sr_q     <= '0;
      r_byte_q        <= '0;
      r_byte_valid_q  <= 1'b0;
      r_frame_start_q <= 1'b0;
      r_lock_q        <= 1'b0;
      r_descr_rstn_q  <= 1'b0;
    end else begin
      r_state_q       <= r_state_d;
      r_cnt_q         <= r_cnt_d;
      r_miss_q        <= r_miss_d;
      r_shreg_q       <= r_shreg_d;
      r_byte_sr_q     <= r_byte_sr_d;
      r_byte_q        <= r_byte_d;
      r_byte_valid_q  <= r_byte_valid_d;
      r_frame_start_q <= r_frame_start_d;
      r_lock_q        <= r_lock_d;
      r_descr_rstn_q  <= r_descr_rstn_d;
    end
  end

  assign bus.descr_rstn_o  = r_descr_rstn_q;
  assign bus.lock_o        = r_lock_q;
  assign bus.frame_start_o = r_frame_start_q;
  assign bus.byte_o        = r_byte_q;
  assign bus.byte_valid_o  = r_byte_valid_q;

`ifdef DESCR_FRAME_STATS_EN
  logic [15:0] r_frame_cnt_q;
  logic [15:0] r_miss_total_q;
  logic        w_miss_evt;

  assign w_miss_evt = (r_state_q == StSync) && bus.en_i && (r_cnt_q == CntW'(SYNC_W - 1)) &&
                      (w_shift != SYNC_WORD);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_frame_cnt_q  <= '0;
      r_miss_total_q <= '0;
    end else begin
      if (r_frame_start_d && r_frame_cnt_q != 16'hFFFF) begin
        r_frame_cnt_q <= r_frame_cnt_q + 16'd1;
      end
      if (w_miss_evt && r_miss_total_q != 16'hFFFF) begin
        r_miss_total_q <= r_miss_total_q + 16'd1;
      end
    end
  end

  assign bus.frame_cnt_o  = r_frame_cnt_q;
  assign bus.miss_total_o = r_miss_total_q;
`else
  assign bus.frame_cnt_o  = 16'h0;
  assign bus.miss_total_o = 16'h0;
`endif

endmodule

// File: doc/descr_frame_ctrl.md
Name: descr_frame_ctrl

Overview:
Sequencing and framing controller for the 12-bit self-synchronising descrambler (polynomial x^12 + x^9 + x^2 + 1).
- Controls the descrambler's reset.
- Discards the flush period while the descrambler's shift register fills.
- Hunts for a frame sync word in the descrambled bit stream, then holds frame lock with a flywheel.
- Deserialises payload into bytes for the downstream byte consumer.
- Runs one bit per clk_i, in lockstep with the descrambler.

Parameters:
SYNC_W, 16, sync word width in bits
SYNC_WORD, 16'hA5F0, descrambled sync pattern, MSB received first
FRAME_BYTES, 8, payload bytes per frame following each sync word
MISS_MAX, 3, consecutive sync mismatches that drop lock (>=1)
FLUSH_LEN, 12, bits discarded after descrambler release

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
en_i  in  1  link enable; level-sensitive
descr_bit_i  in  1  descrambler output bit for the current cycle
descr_rstn_o  out  1  active-low reset to descrambler; registered
lock_o  out  1  frame lock status
frame_start_o  out  1  one-cycle pulse on accepted sync word
byte_o  out  8  deserialised payload byte, MSB first
byte_valid_o  out  1  one-cycle strobe qualifying byte_o
frame_cnt_o  out  16  good-sync count (optional feature)
miss_total_o  out  16  total sync mismatches (optional feature)

Behaviour:
- Reset state:
  - state=IDLE.
  - All outputs 0, including descr_rstn_o=0.
  - Internal counters and shift registers cleared.
- Frame format: SYNC_W sync bits, then FRAME_BYTES*8 payload bits, repeating; no gaps.
- IDLE:
  - descr_rstn_o=0 and lock_o=0.
  - en_i=1 → next cycle state=FLUSH and descr_rstn_o=1.
- FLUSH:
  - Counts FLUSH_LEN cycles; bits are ignored.
  - Sync-pattern shift register cleared on entry.
  - Goes to SEARCH after the FLUSH_LEN-th cycle.
- SEARCH:
  - Each cycle, shreg <= {shreg[SYNC_W-2:0], descr_bit_i}.
  - Match condition: {shreg[SYNC_W-2:0], descr_bit_i} == SYNC_WORD, and at least SYNC_W bits have been shifted since SEARCH entry.
  - On match, next cycle: state=LOCKED (payload phase), lock_o=1, frame_start_o=1 for one cycle, bit counter=0.
- LOCKED, payload phase:
  - Shifts bits into the byte register, MSB first.
  - On the 8th bit of each byte: byte_o = assembled byte, byte_valid_o=1 in the following cycle only.
  - After FRAME_BYTES*8 bits → sync-check phase.
- LOCKED, sync-check phase:
  - Shifts SYNC_W bits and compares on the last bit.
  - Match → miss_cnt=0, frame_start_o pulse, back to payload phase.
  - Mismatch → miss_cnt+1.
    - If that reaches MISS_MAX: next cycle state=SEARCH, lock_o=0, miss_cnt=0; descrambler is not reset because it self-resynchronises.
    - Otherwise (flywheel): lock_o stays 1 and the payload phase proceeds at the predicted position.
  - byte_valid_o is never asserted during sync bits.
- Re-entering SEARCH from LOCKED: shreg is kept, and the SYNC_W-bit minimum restarts.
- en_i=0 in any non-IDLE state, next cycle:
  - state=IDLE, descr_rstn_o=0, lock_o=0.
  - A partial byte is dropped with no byte_valid_o.
  - miss_cnt cleared.
  - A byte_valid_o already scheduled for that same cycle is suppressed.
- byte_valid_o and frame_start_o may never be high in the same cycle; this is inherent in the frame format.
- Width rules:
  - Bit counter sized for max(FLUSH_LEN, FRAME_BYTES*8, SYNC_W).
  - miss_cnt sized clog2(MISS_MAX+1).

Optional Feature:
Macro: DESCR_FRAME_STATS_EN
- Defined:
  - frame_cnt_o increments on each frame_start_o.
  - miss_total_o increments on each sync mismatch in LOCKED.
  - Both are 16-bit, saturating at 16'hFFFF.
  - Both are cleared only by rstn_i; en_i does not clear them.
- Not defined: both ports are present and tied to 16'h0, and no counter logic is built.

Test Plan:
1. Reset/idle: rstn_i pulse with en_i=0 → all outputs 0 and descr_rstn_o=0; descr_rstn_o stays 0 for 20 cycles.
2. Acquisition: set en_i=1 and feed scrambled frames of sync 16'hA5F0 plus payload 01..08.
   - descr_rstn_o=1 one cycle after en_i.
   - lock_o=1 and frame_start_o pulse the cycle after the last sync bit.
   - byte_o=01,02,…,08 with byte_valid_o pulses spaced 8 cycles apart.
3. Flush masking: SYNC_WORD appears entirely inside the first 12 bits after release → no lock; lock only on the next true sync.
4. Flywheel: one frame with sync corrupted to 16'hA5F1 → lock_o stays 1, that frame's 8 bytes are still output, and the next good sync resets miss_cnt (with stats enabled, miss_total_o=1).
5. Loss of lock: 3 consecutive corrupted syncs → lock_o=0 the cycle after the third check, no further byte_valid_o, and re-lock on the next good sync.
6. Mid-byte disable: deassert en_i after 4 payload bits → IDLE next cycle, descr_rstn_o=0, lock_o=0, no byte_valid_o; re-enable → FLUSH restarts.
